// File: rtl/tank_pkg.sv
// Shared tank-arena definitions: grid size, referee state and hit-result encodings,
// and the wall-map tile index helper.
package tank_pkg;

    localparam int GRID_W = 20;
    localparam int GRID_H = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        HIT_NONE = 2'd0,
        HIT_P1   = 2'd1,
        HIT_P2   = 2'd2,
        HIT_DRAW = 2'd3
    } hit_t;

    function automatic int tile_index(input int x, input int y, input int w);
        return y * w + x;
    endfunction

endpackage

// File: rtl/combat_referee_if.sv
// Referee bundle: tank/bullet positions and wall map in, score/round status out.
interface combat_referee_if #(
    parameter int GRID_W  = tank_pkg::GRID_W,
    parameter int GRID_H  = tank_pkg::GRID_H,
    parameter int SCORE_W = 4
);
    logic                       start;
    logic [GRID_W*GRID_H-1:0]   wall;
    logic signed [31:0]         Tank1X, Tank1Y, Tank2X, Tank2Y;
    logic signed [31:0]         Bul1X, Bul1Y, Bul2X, Bul2Y;
    logic                       round_rst;
    logic                       bul1_kill, bul2_kill;
    logic [SCORE_W-1:0]         score1, score2;
    logic [1:0]                 state;
    logic [1:0]                 last_hit;
    logic [1:0]                 winner;

    modport master (
        output start, wall, Tank1X, Tank1Y, Tank2X, Tank2Y,
               Bul1X, Bul1Y, Bul2X, Bul2Y,
        input  round_rst, bul1_kill, bul2_kill, score1, score2,
               state, last_hit, winner
    );

    modport slave (
        input  start, wall, Tank1X, Tank1Y, Tank2X, Tank2Y,
               Bul1X, Bul1Y, Bul2X, Bul2Y,
        output round_rst, bul1_kill, bul2_kill, score1, score2,
               state, last_hit, winner
    );
endinterface

// File: rtl/bullet_probe.sv
// Combinational collision probe for one bullet against the wall map and the opposing tank.
module bullet_probe
    import tank_pkg::*;
#(
    parameter int GRID_W = tank_pkg::GRID_W,
    parameter int GRID_H = tank_pkg::GRID_H
) (
    input  logic signed [31:0]        bul_x,
    input  logic signed [31:0]        bul_y,
    input  logic signed [31:0]        tank_x,
    input  logic signed [31:0]        tank_y,
    input  logic [GRID_W*GRID_H-1:0]  wall,
    output logic                      valid,
    output logic                      oob,
    output logic                      on_wall,
    output logic                      hit
);
    localparam int NTILES = GRID_W * GRID_H;

    logic              x_pos, y_pos;
    logic [NTILES-1:0] tile_sel;

    assign x_pos = (bul_x >= 0);
    assign y_pos = (bul_y >= 0);
    assign valid = x_pos && y_pos && (bul_x < GRID_W) && (bul_y < GRID_H);

    // A negative coordinate means the bullet is parked, not that it left the arena.
    assign oob = x_pos && y_pos && !valid;

    assign tile_sel = {{(NTILES-1){1'b0}}, 1'b1} << tile_index(bul_x, bul_y, GRID_W);
    assign on_wall  = valid && (|(wall & tile_sel));
    assign hit      = valid && !on_wall && (bul_x == tank_x) && (bul_y == tank_y);

endmodule

// File: rtl/combat_referee.sv
// Per-frame referee: bullet collisions, scoring, round/game FSM and round_rst pulse.
//   state    | meaning
//   ST_IDLE  | waiting for start after reset
//   ST_PLAY  | round live, collisions judged every frame
//   ST_PAUSE | hit shown, counting down before next round
//   ST_OVER  | a player reached WIN_SCORE, waiting for start
module combat_referee
    import tank_pkg::*;
#(
    parameter int GRID_W       = tank_pkg::GRID_W,
    parameter int GRID_H       = tank_pkg::GRID_H,
    parameter int WIN_SCORE    = 5,
    parameter int PAUSE_FRAMES = 60,
    parameter int SCORE_W      = 4
) (
    input logic             frame_clk,
    input logic             Reset,
    combat_referee_if.slave bus
);
    localparam int                   CNT_W      = $clog2(PAUSE_FRAMES + 1);
    localparam logic [CNT_W-1:0]     PAUSE_LOAD = CNT_W'(PAUSE_FRAMES - 1);
    localparam logic [SCORE_W-1:0]   WIN        = SCORE_W'(WIN_SCORE);

    state_t               state_q, state_d;
    hit_t                 last_hit_q, last_hit_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SCORE_W-1:0]   score1_q, score1_d, score2_q, score2_d;
    logic [SCORE_W-1:0]   score1_inc, score2_inc;
    logic [1:0]           winner_q, winner_d;
    logic                 round_rst_q, round_rst_d;
    logic                 bul1_kill_q, bul1_kill_d, bul2_kill_q, bul2_kill_d;

    logic valid1, oob1, wall1, hit1;
    logic valid2, oob2, wall2, hit2;

    bullet_probe #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_probe1 (
        .bul_x   (bus.Bul1X),
        .bul_y   (bus.Bul1Y),
        .tank_x  (bus.Tank2X),
        .tank_y  (bus.Tank2Y),
        .wall    (bus.wall),
        .valid   (valid1),
        .oob     (oob1),
        .on_wall (wall1),
        .hit     (hit1)
    );

    bullet_probe #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_probe2 (
        .bul_x   (bus.Bul2X),
        .bul_y   (bus.Bul2Y),
        .tank_x  (bus.Tank1X),
        .tank_y  (bus.Tank1Y),
        .wall    (bus.wall),
        .valid   (valid2),
        .oob     (oob2),
        .on_wall (wall2),
        .hit     (hit2)
    );

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s >= WIN) ? s : s + SCORE_W'(1);
    endfunction

    assign score1_inc = sat_inc(score1_q);
    assign score2_inc = sat_inc(score2_q);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            last_hit_q  <= HIT_NONE;
            cnt_q       <= '0;
            score1_q    <= '0;
            score2_q    <= '0;
            winner_q    <= 2'd0;
            round_rst_q <= 1'b0;
            bul1_kill_q <= 1'b0;
            bul2_kill_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_hit_q  <= last_hit_d;
            cnt_q       <= cnt_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            winner_q    <= winner_d;
            round_rst_q <= round_rst_d;
            bul1_kill_q <= bul1_kill_d;
            bul2_kill_q <= bul2_kill_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_hit_d  = last_hit_q;
        cnt_d       = cnt_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        winner_d    = winner_q;
        bul1_kill_d = 1'b0;
        bul2_kill_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    state_d    = ST_PLAY;
                    score1_d   = '0;
                    score2_d   = '0;
                    last_hit_d = HIT_NONE;
                    winner_d   = 2'd0;
                end
            end
            ST_PLAY: begin
                bul1_kill_d = oob1 || (valid1 && (wall1 || hit1));
                bul2_kill_d = oob2 || (valid2 && (wall2 || hit2));
                if (hit1 && hit2) begin
                    last_hit_d = HIT_DRAW;
                    state_d    = ST_PAUSE;
                    cnt_d      = PAUSE_LOAD;
                end else if (hit1) begin
                    score1_d   = score1_inc;
                    last_hit_d = HIT_P1;
                    if (score1_inc == WIN) begin
                        state_d  = ST_OVER;
                        winner_d = 2'd1;
                    end else begin
                        state_d = ST_PAUSE;
                        cnt_d   = PAUSE_LOAD;
                    end
                end else if (hit2) begin
                    score2_d   = score2_inc;
                    last_hit_d = HIT_P2;
                    if (score2_inc == WIN) begin
                        state_d  = ST_OVER;
                        winner_d = 2'd2;
                    end else begin
                        state_d = ST_PAUSE;
                        cnt_d   = PAUSE_LOAD;
                    end
                end
            end
            ST_PAUSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_PLAY;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase

        // Tanks are re-seated on every entry into PLAY, whatever the source state.
        round_rst_d = (state_d == ST_PLAY) && (state_q != ST_PLAY);
    end

    assign bus.state     = state_q;
    assign bus.last_hit  = last_hit_q;
    assign bus.score1    = score1_q;
    assign bus.score2    = score2_q;
    assign bus.winner    = winner_q;
    assign bus.round_rst = round_rst_q;
    assign bus.bul1_kill = bul1_kill_q;
    assign bus.bul2_kill = bul2_kill_q;

endmodule

// File: tb/tb_combat_referee.sv
// Self-checking bench for combat_referee: frame-level model plus directed literal checks.
module tb_combat_referee;
    localparam int W   = 20;
    localparam int H   = 15;
    localparam int WIN = 5;
    localparam int PF  = 60;

    logic frame_clk = 1'b0;
    logic Reset;

    combat_referee_if #(.GRID_W(W), .GRID_H(H), .SCORE_W(4)) cif ();

    combat_referee #(
        .GRID_W(W), .GRID_H(H), .WIN_SCORE(WIN), .PAUSE_FRAMES(PF), .SCORE_W(4)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (cif.slave)
    );

    always #5 frame_clk = ~frame_clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit run_cmp = 1'b0;

    // Model state: plain integers following the game rules frame by frame.
    int m_st, m_s1, m_s2, m_last, m_win, m_left, m_rr, m_k1, m_k2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_s1 = 0; m_s2 = 0; m_last = 0; m_win = 0;
        m_left = 0; m_rr = 0; m_k1 = 0; m_k2 = 0;
    endtask

    task automatic probe(input int bx, input int by, input int tx, input int ty,
                         output bit kill, output bit hit);
        bit on_grid, off_grid, on_wall;
        on_grid  = (bx >= 0) && (bx < W) && (by >= 0) && (by < H);
        off_grid = (bx >= 0) && (by >= 0) && !on_grid;
        on_wall  = on_grid && (cif.wall[by * W + bx] == 1'b1);
        hit      = on_grid && !on_wall && (bx == tx) && (by == ty);
        kill     = off_grid || on_wall || hit;
    endtask

    task automatic model_step();
        bit k1, h1, k2, h2;
        if (Reset) begin
            model_reset();
            return;
        end
        m_rr = 0; m_k1 = 0; m_k2 = 0;
        case (m_st)
            0, 3: if (cif.start) begin
                m_st = 1; m_s1 = 0; m_s2 = 0; m_last = 0; m_win = 0; m_rr = 1;
            end
            1: begin
                probe(cif.Bul1X, cif.Bul1Y, cif.Tank2X, cif.Tank2Y, k1, h1);
                probe(cif.Bul2X, cif.Bul2Y, cif.Tank1X, cif.Tank1Y, k2, h2);
                m_k1 = k1; m_k2 = k2;
                if (h1 && h2) begin
                    m_last = 3; m_st = 2; m_left = PF;
                end else if (h1) begin
                    if (m_s1 < WIN) m_s1++;
                    m_last = 1;
                    if (m_s1 == WIN) begin m_st = 3; m_win = 1; end
                    else begin m_st = 2; m_left = PF; end
                end else if (h2) begin
                    if (m_s2 < WIN) m_s2++;
                    m_last = 2;
                    if (m_s2 == WIN) begin m_st = 3; m_win = 2; end
                    else begin m_st = 2; m_left = PF; end
                end
            end
            2: begin
                m_left--;
                if (m_left == 0) begin m_st = 1; m_rr = 1; end
            end
            default: ;
        endcase
    endtask

    // Advance one frame: model consumes current inputs, then observe after the edge.
    task automatic tick();
        model_step();
        @(posedge frame_clk);
        @(negedge frame_clk);
        #1;
    endtask

    always @(negedge frame_clk) begin
        if (run_cmp) begin
            chk("m_state",     cif.state,     m_st);
            chk("m_score1",    cif.score1,    m_s1);
            chk("m_score2",    cif.score2,    m_s2);
            chk("m_last_hit",  cif.last_hit,  m_last);
            chk("m_winner",    cif.winner,    m_win);
            chk("m_round_rst", cif.round_rst, m_rr);
            chk("m_bul1_kill", cif.bul1_kill, m_k1);
            chk("m_bul2_kill", cif.bul2_kill, m_k2);
        end
    end

    task automatic park();
        cif.Bul1X = -1; cif.Bul1Y = -1; cif.Bul2X = -1; cif.Bul2Y = -1;
    endtask

    task automatic shot1(input int x, input int y);
        cif.Bul1X = x; cif.Bul1Y = y;
        tick();
    endtask

    // Called in the first PAUSE frame; counts frames until PLAY returns.
    task automatic wait_play();
        int n;
        n = 1;
        park();
        while (cif.state != 2'd1) begin
            if (n > 3 * PF) begin
                n_cmp++; n_bad++;
                $display("FAIL pause_timeout: state %0d after %0d frames, wanted 1", cif.state, n);
                return;
            end
            tick();
            n++;
        end
        chk("pause_len", n - 1, PF);
        chk("pause_rr", cif.round_rst, 1);
        tick();
        chk("pause_rr_drop", cif.round_rst, 0);
    endtask

    initial begin
        logic [W*H-1:0] wmap;
        Reset = 1'b1;
        wmap = '0;
        wmap[105] = 1'b1;
        wmap[0]   = 1'b1;
        cif.wall = wmap;
        cif.start = 1'b0;
        cif.Tank1X = 1;  cif.Tank1Y = 13;
        cif.Tank2X = 18; cif.Tank2Y = 1;
        park();
        model_reset();
        tick();
        run_cmp = 1'b1;
        tick();
        chk("rst_state", cif.state, 0);
        chk("rst_score1", cif.score1, 0);
        Reset = 1'b0;
        tick();
        tick();
        chk("idle_hold", cif.state, 0);

        cif.start = 1'b1; tick(); cif.start = 1'b0;
        chk("start_state", cif.state, 1);
        chk("start_rr", cif.round_rst, 1);
        tick();
        chk("start_rr_drop", cif.round_rst, 0);

        shot1(5, 5);
        chk("wall_kill", cif.bul1_kill, 1);
        chk("wall_state", cif.state, 1);
        park(); tick();
        chk("wall_kill_drop", cif.bul1_kill, 0);
        shot1(20, 3);
        chk("oob_kill", cif.bul1_kill, 1);
        shot1(-1, 5);
        chk("inactive_nokill", cif.bul1_kill, 0);
        shot1(1, 13);
        chk("self_hit_ignored", cif.score1, 0);
        shot1(19, 14);
        chk("corner_nokill", cif.bul1_kill, 0);
        cif.Tank2X = 5; cif.Tank2Y = 5;
        shot1(5, 5);
        chk("tank_on_wall_score", cif.score1, 0);
        chk("tank_on_wall_kill", cif.bul1_kill, 1);
        cif.Tank2X = 18; cif.Tank2Y = 1;

        shot1(18, 1);
        chk("p1_score", cif.score1, 1);
        chk("p1_last", cif.last_hit, 1);
        chk("p1_state", cif.state, 2);
        wait_play();

        cif.Bul1X = 18; cif.Bul1Y = 1; cif.Bul2X = 1; cif.Bul2Y = 13;
        tick();
        chk("draw_last", cif.last_hit, 3);
        chk("draw_k1", cif.bul1_kill, 1);
        chk("draw_k2", cif.bul2_kill, 1);
        chk("draw_score1", cif.score1, 1);
        chk("draw_state", cif.state, 2);
        wait_play();

        cif.Bul2X = 1; cif.Bul2Y = 13;
        tick();
        chk("p2_score", cif.score2, 1);
        chk("p2_last", cif.last_hit, 2);
        wait_play();

        for (int i = 2; i <= 4; i++) begin
            shot1(18, 1);
            chk("p1_run_score", cif.score1, i);
            wait_play();
        end
        shot1(18, 1);
        chk("win_score", cif.score1, 5);
        chk("win_state", cif.state, 3);
        chk("win_winner", cif.winner, 1);
        park(); tick();
        shot1(18, 1);
        chk("over_ignore_score", cif.score1, 5);
        chk("over_ignore_kill", cif.bul1_kill, 0);
        park();
        cif.start = 1'b1; tick(); cif.start = 1'b0;
        chk("restart_state", cif.state, 1);
        chk("restart_score1", cif.score1, 0);
        chk("restart_winner", cif.winner, 0);
        chk("restart_rr", cif.round_rst, 1);

        shot1(18, 1);
        chk("pre_rst_state", cif.state, 2);
        park();
        for (int i = 0; i < 29; i++) tick();
        #2;
        Reset = 1'b1;
        model_reset();
        #1;
        chk("arst_state", cif.state, 0);
        chk("arst_score1", cif.score1, 0);
        chk("arst_last", cif.last_hit, 0);
        chk("arst_rr", cif.round_rst, 0);
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("arst_needs_start", cif.state, 0);
        cif.start = 1'b1; tick(); cif.start = 1'b0;
        chk("resume_state", cif.state, 1);
        chk("resume_rr", cif.round_rst, 1);
        shot1(18, 1);
        chk("resume_score", cif.score1, 1);
        wait_play();

        run_cmp = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
